psmac_operand_packer: RTL and testbench

- Producer side of the precision-scalable MAC operand interface.
- Accepts a stream of operand pairs (activation, weight) one pair per cycle over a valid/ready handshake.
- Packs each stream into the 32-bit ip/wt words, the per-2-bit-slice sign vectors sx1..sx4/sy1..sy4, and the mode1/mode2 precision selects consumed by the MAC array.
- Double-buffered: fill buffer plus output register, so one pair per cycle is sustained under continuous m_ready.

---
 rtl/psmac_operand_packer.sv | 201 ++++++++++++++++++++
 tb/tb_psmac_operand_packer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psmac_operand_packer.sv
// Producer side of the precision-scalable MAC operand interface. It packs
// (activation, weight) pairs into 32-bit words with 2-bit-slice sign flags.
// A fill buffer and an output register together sustain one pair per cycle.

module psmac_operand_slice #(
  parameter int SLICE = 0
) (
  input  logic [1:0] md,       // format of the lane being written: 0=2b 1=4b 2=8b
  input  logic [3:0] cnt,
  input  logic [7:0] ip_d,
  input  logic [7:0] wt_d,
  input  logic [1:0] flag_md,  // format of the word whose flags are produced
  input  logic       sgx,
  input  logic       sgy,
  output logic [1:0] ip_s,
  output logic [1:0] wt_s,
  output logic       sx,
  output logic       sy
);
  localparam logic [3:0] S = SLICE[3:0];

  logic [3:0] lane;
  logic [1:0] sub;
  logic       top;

  always_comb begin
    lane = S;
    sub  = 2'd0;
    case (md)
      2'd0:    begin lane = S;               sub = 2'd0;          end
      2'd1:    begin lane = {1'b0, S[3:1]};  sub = {1'b0, S[0]};  end
      default: begin lane = {2'b00, S[3:2]}; sub = S[1:0];        end
    endcase
  end

  always_comb begin
    case (flag_md)
      2'd0:    top = 1'b1;
      2'd1:    top = S[0];
      default: top = &S[1:0];
    endcase
  end

  assign ip_s = (lane == cnt) ? ip_d[{sub, 1'b0} +: 2] : 2'b00;
  assign wt_s = (lane == cnt) ? wt_d[{sub, 1'b0} +: 2] : 2'b00;
  assign sx   = sgx & top;
  assign sy   = sgy & top;
endmodule

module psmac_operand_packer #(
  parameter int DATA_W              = 8,
  parameter bit PREC_RESERVED_AS_8B = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        prec,
  input  logic              signed_x,
  input  logic              signed_y,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_ip,
  input  logic [DATA_W-1:0] s_wt,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       ip,
  output logic [31:0]       wt,
  output logic [3:0]        sx1,
  output logic [3:0]        sx2,
  output logic [3:0]        sx3,
  output logic [3:0]        sx4,
  output logic [3:0]        sy1,
  output logic [3:0]        sy2,
  output logic [3:0]        sy3,
  output logic [3:0]        sy4,
  output logic              mode1,
  output logic              mode2
);
  localparam int NSLICE = 16;

  typedef enum logic [1:0] {EMPTY, FILL, HELD} state_t;

  typedef struct packed {
    logic [31:0] ip;
    logic [31:0] wt;
    logic [1:0]  md;
    logic        sgx;
    logic        sgy;
  } word_t;

  state_t                  state;
  logic [3:0]              cnt;
  word_t                   fb, nw, src;
  logic [1:0]              in_md;
  logic [3:0]              lmax;
  logic                    acc, close, out_free, load;
  logic [NSLICE-1:0][1:0]  ip_ins, wt_ins;
  logic [NSLICE-1:0]       sxv, syv;

  // Reserved precision falls back to 2b when not aliased to 8b.
  always_comb begin
    case (prec)
      2'd0:    in_md = 2'd0;
      2'd1:    in_md = 2'd1;
      2'd2:    in_md = 2'd2;
      default: in_md = PREC_RESERVED_AS_8B ? 2'd2 : 2'd0;
    endcase
  end

  // Lane 0 takes the live configuration; later lanes reuse the latched one.
  always_comb begin
    nw.md  = (cnt == 4'd0) ? in_md    : fb.md;
    nw.sgx = (cnt == 4'd0) ? signed_x : fb.sgx;
    nw.sgy = (cnt == 4'd0) ? signed_y : fb.sgy;
    nw.ip  = ((cnt == 4'd0) ? 32'd0 : fb.ip) | ip_ins;
    nw.wt  = ((cnt == 4'd0) ? 32'd0 : fb.wt) | wt_ins;
  end

  always_comb begin
    case (nw.md)
      2'd0:    lmax = 4'd15;
      2'd1:    lmax = 4'd7;
      default: lmax = 4'd3;
    endcase
  end

  assign acc      = s_valid && s_ready;
  assign close    = acc && (s_last || (cnt == lmax));
  assign out_free = !m_valid || m_ready;
  assign src      = (state == HELD) ? fb : nw;
  assign load     = out_free && ((state == HELD) || close);

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    psmac_operand_slice #(.SLICE(s)) u_slice (
      .md      (nw.md),
      .cnt     (cnt),
      .ip_d    (s_ip),
      .wt_d    (s_wt),
      .flag_md (src.md),
      .sgx     (src.sgx),
      .sgy     (src.sgy),
      .ip_s    (ip_ins[s]),
      .wt_s    (wt_ins[s]),
      .sx      (sxv[s]),
      .sy      (syv[s])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      cnt     <= '0;
      fb      <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      ip      <= '0;
      wt      <= '0;
      sx1     <= '0;
      sx2     <= '0;
      sx3     <= '0;
      sx4     <= '0;
      sy1     <= '0;
      sy2     <= '0;
      sy3     <= '0;
      sy4     <= '0;
      mode1   <= 1'b0;
      mode2   <= 1'b0;
    end else begin
      case (state)
        EMPTY, FILL: begin
          if (acc) begin
            fb    <= nw;
            cnt   <= close ? 4'd0 : cnt + 4'd1;
            state <= !close ? FILL : (out_free ? EMPTY : HELD);
          end
        end
        HELD:    if (out_free) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      // Ready drops exactly when the next state is HELD.
      s_ready <= !(!out_free && ((state == HELD) || close));
      if (load) begin
        m_valid <= 1'b1;
        ip      <= src.ip;
        wt      <= src.wt;
        sx1     <= sxv[3:0];
        sx2     <= sxv[7:4];
        sx3     <= sxv[11:8];
        sx4     <= sxv[15:12];
        sy1     <= syv[3:0];
        sy2     <= syv[7:4];
        sy3     <= syv[11:8];
        sy4     <= syv[15:12];
        mode1   <= (src.md != 2'd0);
        mode2   <= (src.md == 2'd2);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_psmac_operand_packer.sv
// Directed bench for psmac_operand_packer: literal word checks plus a queue
// model of accepted pairs compared against every handshake.
`timescale 1ns/1ps
module tb_psmac_operand_packer;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [1:0]  prec = 2'd0;
  logic        signed_x = 1'b0, signed_y = 1'b0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0]  s_ip = '0, s_wt = '0;
  logic        m_valid, m_ready = 1'b1;
  logic [31:0] ip, wt;
  logic [3:0]  sx1, sx2, sx3, sx4, sy1, sy2, sy3, sy4;
  logic        mode1, mode2;

  always #5 clk = ~clk;

  psmac_operand_packer dut (
    .clk(clk), .rst_n(rst_n), .prec(prec), .signed_x(signed_x), .signed_y(signed_y),
    .s_valid(s_valid), .s_ready(s_ready), .s_ip(s_ip), .s_wt(s_wt), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .ip(ip), .wt(wt),
    .sx1(sx1), .sx2(sx2), .sx3(sx3), .sx4(sx4), .sy1(sy1), .sy2(sy2), .sy3(sy3), .sy4(sy4),
    .mode1(mode1), .mode2(mode2)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ip, wt;
    logic [15:0] sx, sy;
    logic        m1, m2;
  } word_t;

  word_t       q[$];
  word_t       w, snap;
  int          lanes = 0, lw = 2;
  bit          lsx, lsy, was_rst = 1'b1, stall = 1'b0;
  logic [31:0] aip, awt;

  function automatic word_t cur();
    word_t c;
    c.ip = ip; c.wt = wt;
    c.sx = {sx4, sx3, sx2, sx1};
    c.sy = {sy4, sy3, sy2, sy1};
    c.m1 = mode1; c.m2 = mode2;
    return c;
  endfunction

  // Word model: lane i of width lw sits at bit lw*i; flags mark each lane's top slice.
  task automatic model_accept();
    word_t  nw;
    longint m;
    if (lanes == 0) begin
      lw  = (prec == 2'd0) ? 2 : (prec == 2'd1) ? 4 : 8;
      lsx = signed_x; lsy = signed_y;
      aip = '0; awt = '0;
    end
    m   = longint'(1) << lw;
    aip = aip + 32'((longint'(s_ip) % m) << (lw * lanes));
    awt = awt + 32'((longint'(s_wt) % m) << (lw * lanes));
    lanes++;
    if (lanes == 32 / lw || s_last) begin
      nw.ip = aip; nw.wt = awt;
      for (int s = 0; s < 16; s++) begin
        nw.sx[s] = lsx && (((2 * s + 2) % lw) == 0);
        nw.sy[s] = lsy && (((2 * s + 2) % lw) == 0);
      end
      nw.m1 = (lw != 2);
      nw.m2 = (lw == 8);
      q.push_back(nw);
      lanes = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      lanes   = 0;
      was_rst = 1'b1;
      stall   = 1'b0;
    end else begin
      chk("m_valid_vs_model", m_valid, q.size() > 0);
      if (!was_rst) chk("s_ready_vs_model", s_ready, q.size() < 2);
      was_rst = 1'b0;
      if (stall) begin
        chk("hold_ip", ip, snap.ip);
        chk("hold_wt", wt, snap.wt);
        chk("hold_flags", {cur().sx, cur().sy}, {snap.sx, snap.sy});
        chk("hold_mode", {mode2, mode1}, {snap.m2, snap.m1});
      end
      stall = m_valid && !m_ready;
      snap  = cur();
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          w = q.pop_front();
          chk("xfer_ip", ip, w.ip);
          chk("xfer_wt", wt, w.wt);
          chk("xfer_sx", {sx4, sx3, sx2, sx1}, w.sx);
          chk("xfer_sy", {sy4, sy3, sy2, sy1}, w.sy);
          chk("xfer_mode", {mode2, mode1}, {w.m2, w.m1});
        end
      end
      if (s_valid && s_ready) model_accept();
    end
  end

  task automatic send(input logic [1:0] p, input logic gx, input logic gy,
                      input logic [7:0] a, input logic [7:0] b, input logic last);
    int t = 0;
    prec = p; signed_x = gx; signed_y = gy;
    s_ip = a; s_wt = b; s_last = last; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 50) begin
        chk("s_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic chk_word(input string nm, input logic [31:0] eip, input logic [31:0] ewt,
                          input logic [15:0] esx, input logic [15:0] esy,
                          input logic em1, input logic em2);
    chk({nm, "_mvalid"}, m_valid, 1);
    chk({nm, "_ip"}, ip, eip);
    chk({nm, "_wt"}, wt, ewt);
    chk({nm, "_sx"}, {sx4, sx3, sx2, sx1}, esx);
    chk({nm, "_sy"}, {sy4, sy3, sy2, sy1}, esy);
    chk({nm, "_mode"}, {mode2, mode1}, {em2, em1});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_mvalid"}, m_valid, 0);
    chk({nm, "_ip"}, ip, 0);
    chk({nm, "_wt"}, wt, 0);
    chk({nm, "_flags"}, {sx4, sx3, sx2, sx1, sy4, sy3, sy2, sy1}, 0);
    chk({nm, "_mode"}, {mode2, mode1}, 0);
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    chk("reset_sready", s_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("sready_after_reset", s_ready, 1);

    // 2b full word
    for (int i = 0; i < 16; i++) send(2'd0, 1'b1, 1'b0, 8'h01, 8'h03, 1'b0);
    chk_word("w2b", 32'h55555555, 32'hFFFFFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

    // 8b full word
    send(2'd2, 1'b1, 1'b1, 8'h12, 8'h01, 1'b0);
    send(2'd2, 1'b1, 1'b1, 8'h34, 8'h02, 1'b0);
    send(2'd2, 1'b1, 1'b1, 8'h56, 8'h03, 1'b0);
    send(2'd2, 1'b1, 1'b1, 8'h78, 8'h04, 1'b0);
    chk_word("w8b", 32'h78563412, 32'h04030201, 16'h8888, 16'h8888, 1'b1, 1'b1);

    // 4b partial word closed by s_last
    send(2'd1, 1'b1, 1'b0, 8'h0A, 8'h05, 1'b0);
    send(2'd1, 1'b1, 1'b0, 8'h03, 8'h06, 1'b0);
    send(2'd1, 1'b1, 1'b0, 8'h07, 8'h01, 1'b1);
    chk_word("w4b_part", 32'h0000073A, 32'h00000165, 16'hAAAA, 16'h0000, 1'b1, 1'b0);
    drain();

    // single-pair word
    send(2'd2, 1'b0, 1'b1, 8'hC3, 8'h5A, 1'b1);
    chk_word("w_single", 32'h000000C3, 32'h0000005A, 16'h0000, 16'h8888, 1'b1, 1'b1);
    drain();

    // backpressure: two 8b words, second one held
    m_ready = 1'b0;
    send(2'd2, 1'b0, 1'b0, 8'h11, 8'hA1, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h22, 8'hA2, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h33, 8'hA3, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h44, 8'hA4, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h55, 8'hB1, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h66, 8'hB2, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h77, 8'hB3, 1'b0);
    send(2'd2, 1'b0, 1'b0, 8'h88, 8'hB4, 1'b0);
    chk("bp_sready_held", s_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_word("bp_word1", 32'h44332211, 32'hA4A3A2A1, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("bp_sready_still", s_ready, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk_word("bp_word2", 32'h88776655, 32'hB4B3B2B1, 16'h0, 16'h0, 1'b1, 1'b1);
    chk("bp_sready_back", s_ready, 1);
    @(posedge clk); #1;
    chk("bp_empty", m_valid, 0);

    // config change mid-word is ignored until the next word
    for (int i = 0; i < 16; i++) begin
      if (i < 6) send(2'd0, 1'b1, 1'b0, 8'(i), 8'h02, 1'b0);
      else       send(2'd2, 1'b0, 1'b1, 8'(i), 8'h02, 1'b0);
    end
    chk_word("cfg_2b", 32'hE4E4E4E4, 32'hAAAAAAAA, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send(2'd2, 1'b0, 1'b1, 8'hA5, 8'h3C, 1'b0);
    chk_word("cfg_8b", 32'hA5A5A5A5, 32'h3C3C3C3C, 16'h0000, 16'h8888, 1'b1, 1'b1);

    // reset mid-fill discards the partial word
    for (int i = 0; i < 5; i++) send(2'd0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_zero("midfill_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(2'd0, 1'b0, 1'b0, 8'h02, 8'h01, 1'b0);
    chk_word("post_reset", 32'hAAAAAAAA, 32'h55555555, 16'h0, 16'h0, 1'b0, 1'b0);
    drain();
    chk("model_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
